data_sram_like_resp: RTL and testbench



---
 rtl/data_sram_like_resp.sv | 108 ++++++++++
 tb/tb_data_sram_like_resp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_like_resp.sv
// SRAM-like data-bus responder: local word memory, in-order response queue, fixed LAT response delay.
// Define RAND_DELAY_EN to add an LFSR-driven extra delay of 0..7 cycles per response.
module data_sram_like_resp #(
   parameter int ADDR_W = 10,
   parameter int QDEPTH = 4,
   parameter int LAT    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int PTR_W     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W     = PTR_W + 1;
   localparam int DLY_W     = $clog2(LAT + 8) + 1;
   localparam int MEM_DEPTH = 1 << ADDR_W;

   logic [31:0]       r_mem    [MEM_DEPTH];
   logic [31:0]       r_q_data [QDEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic [DLY_W-1:0]  r_dly;

   logic [ADDR_W-1:0] w_idx;
   logic              w_push;
   logic              w_pop;
   logic [DLY_W-1:0]  w_target;
   logic              w_unused;

   // size and the aliased/sub-word address bits carry no meaning for this memory
   assign w_unused = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
   assign w_idx    = data_sram_addr[ADDR_W+1:2];

   assign data_sram_addr_ok = data_sram_req && (r_count < CNT_W'(QDEPTH));
   assign w_push            = data_sram_req && data_sram_addr_ok;
   assign data_sram_data_ok = (r_count != '0) && (r_dly == w_target - 1'b1);
   assign w_pop             = data_sram_data_ok;
   assign data_sram_rdata   = data_sram_data_ok ? r_q_data[r_rptr] : 32'h0;

`ifdef RAND_DELAY_EN
   logic [15:0] r_lfsr;
   logic [2:0]  r_extra;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_lfsr  <= 16'hACE1;
         r_extra <= 3'd0;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
         if (w_pop)
            r_extra <= r_lfsr[2:0];
      end
   end

   assign w_target = DLY_W'(LAT) + DLY_W'(r_extra);
`else
   assign w_target = DLY_W'(LAT);
`endif

   // Read data is captured from the pre-edge memory word; writes store a zero response.
   always_ff @(posedge clk) begin
      if (w_push)
         r_q_data[r_wptr] <= data_sram_wr ? 32'h0 : r_mem[w_idx];
   end

   always_ff @(posedge clk) begin
      if (w_push && data_sram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wstrb[i])
               r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_dly   <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // The delay counter restarts for every new head and idles at zero when empty.
         if (w_pop || (r_count == '0))
            r_dly <= '0;
         else
            r_dly <= r_dly + 1'b1;
      end
   end

endmodule

// File: tb/tb_data_sram_like_resp.sv
// Randomized scoreboard bench for data_sram_like_resp in its default (fixed-latency) build.
module tb_data_sram_like_resp;

   localparam int ADDR_W = 10;
   localparam int QDEPTH = 4;
   localparam int LAT    = 2;

   typedef struct {
      logic [31:0] data;
      int unsigned pop_edge;
   } exp_t;

   logic        clk;
   logic        resetn;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   int unsigned last_pop = 0;
   exp_t        mq[$];
   logic [31:0] mmem [1 << ADDR_W];

   data_sram_like_resp #(.ADDR_W(ADDR_W), .QDEPTH(QDEPTH), .LAT(LAT)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .data_sram_req    (req),
      .data_sram_wr     (wr),
      .data_sram_size   (size),
      .data_sram_addr   (addr),
      .data_sram_wstrb  (wstrb),
      .data_sram_wdata  (wdata),
      .data_sram_addr_ok(addr_ok),
      .data_sram_data_ok(data_ok),
      .data_sram_rdata  (rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Reference: responses leave in order, each LAT edges after it is accepted or after its predecessor left.
   task automatic model_accept(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      exp_t        e;
      int unsigned acc;
      int          idx;
      idx    = int'(a[ADDR_W+1:2]);
      e.data = w ? 32'h0 : mmem[idx];
      if (w)
         for (int i = 0; i < 4; i++)
            if (s[i]) mmem[idx][8*i +: 8] = d[8*i +: 8];
      acc        = cyc + 1;
      e.pop_edge = ((acc > last_pop) ? acc : last_pop) + LAT;
      last_pop   = e.pop_edge;
      mq.push_back(e);
   endtask

   task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      bit done;
      int tries;
      bit want_ok;
      done  = 0;
      tries = 0;
      while (!done) begin
         @(negedge clk);
         req   = 1'b1;
         wr    = w;
         addr  = a;
         wstrb = s;
         wdata = d;
         size  = 2'($urandom_range(0, 2));
         #1;
         want_ok = (mq.size() < QDEPTH);
         check("addr_ok", {31'b0, addr_ok}, {31'b0, want_ok});
         if (want_ok) begin
            model_accept(w, a, s, d);
            done = 1;
         end else if (++tries > 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: request at %h never accepted, expected acceptance", a);
            done = 1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         req = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (mq.size() > 0 && n < 300) begin
         @(negedge clk);
         req = 1'b0;
         n++;
      end
      total++;
      if (mq.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d responses still pending, expected 0", mq.size());
         mq.delete();
      end
   endtask

   function automatic logic [31:0] mkaddr(input int idx);
      logic [31:0] hi;
      hi = $urandom;
      return (hi & 32'hFFFF_F000) | (32'(idx) << 2) | (hi & 32'h3);
   endfunction

   // Monitor: every cycle compare data_ok/rdata against the scoreboard head.
   initial begin
      logic        want_ok;
      logic [31:0] want_rd;
      forever begin
         @(negedge clk);
         #2;
         want_ok = 1'b0;
         want_rd = 32'h0;
         if (mq.size() > 0 && mq[0].pop_edge == cyc + 1) begin
            want_ok = 1'b1;
            want_rd = mq[0].data;
            void'(mq.pop_front());
         end
         check("data_ok", {31'b0, data_ok}, {31'b0, want_ok});
         check("rdata", rdata, want_rd);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      req    = 1'b0;
      wr     = 1'b0;
      size   = 2'd0;
      addr   = 32'h0;
      wstrb  = 4'h0;
      wdata  = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_addr_ok", {31'b0, addr_ok}, 32'h0);
      check("reset_data_ok", {31'b0, data_ok}, 32'h0);
      check("reset_rdata", rdata, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      #1;
      check("idle_addr_ok", {31'b0, addr_ok}, 32'h0);

      // Preload the word window used by the rest of the run.
      for (int i = 0; i < 16; i++) issue(1'b1, mkaddr(i), 4'hF, $urandom);
      drain();

      // Write then read, write response returns zero.
      issue(1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678);
      idle(3);
      issue(1'b0, 32'h0000_0010, 4'hF, 32'h0);
      drain();

      // Byte-lane strobe.
      issue(1'b1, 32'h0000_0010, 4'hF, 32'hAABB_CCDD);
      issue(1'b1, 32'h0000_0010, 4'b0100, 32'h0011_2233);
      issue(1'b0, 32'h0000_0010, 4'h0, 32'h0);
      drain();

      // Read captured before a following write to the same word.
      issue(1'b1, 32'h0000_0020, 4'hF, 32'h0000_0005);
      drain();
      issue(1'b0, 32'h0000_0020, 4'h0, 32'h0);
      issue(1'b1, 32'h0000_0020, 4'hF, 32'h0000_0009);
      issue(1'b0, 32'h0000_0020, 4'h0, 32'h0);
      drain();

      // Fill the queue with back-to-back reads, req held high.
      for (int i = 0; i < 7; i++) issue(1'b0, mkaddr(i), 4'h0, 32'h0);
      drain();

      // Random traffic with aliased high address bits.
      for (int n = 0; n < 400; n++) begin
         issue(1'($urandom_range(0, 1)), mkaddr($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      drain();

      // Asynchronous reset with reads outstanding.
      for (int i = 0; i < 3; i++) issue(1'b0, mkaddr(i), 4'h0, 32'h0);
      @(negedge clk);
      req = 1'b0;
      #3;
      resetn = 1'b0;
      #1;
      check("midreset_data_ok", {31'b0, data_ok}, 32'h0);
      check("midreset_addr_ok", {31'b0, addr_ok}, 32'h0);
      check("midreset_rdata", rdata, 32'h0);
      mq.delete();
      last_pop = 0;
      #4;
      resetn = 1'b1;
      idle(4);
      for (int i = 0; i < 16; i++) issue(1'b0, mkaddr(i), 4'h0, 32'h0);
      drain();
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
